// File: rtl/bnn_ctrl_pkg.sv
// Shared state encoding, default geometry and vector typedefs for the BNN layer sequencer.
package bnn_ctrl_pkg;

    localparam int INPUT_DIM_D  = 4;
    localparam int OUTPUT_DIM_D = 8;
    localparam int BIT_CNT_D    = 8;
    localparam int TILE_OUT_D   = 2;
    localparam int DP_LAT_D     = 1;
    localparam int NPASS        = OUTPUT_DIM_D / TILE_OUT_D;

    typedef enum logic [1:0] {IDLE, SETTLE, OUTPUT} state_e;

    typedef logic [INPUT_DIM_D-1:0][BIT_CNT_D-1:0] vec_t;
    typedef logic [INPUT_DIM_D-1:0]                row_t;
    typedef logic [TILE_OUT_D-1:0][INPUT_DIM_D-1:0] tile_w_t;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_weight_bank.sv
// Binary weight matrix: one row-write port, one TILE_OUT-row read port selected by pass number.
module bnn_weight_bank
    import bnn_ctrl_pkg::*;
#(
    parameter int INPUT_DIM  = INPUT_DIM_D,
    parameter int OUTPUT_DIM = OUTPUT_DIM_D,
    parameter int TILE_OUT   = TILE_OUT_D,
    parameter int IDX_W      = cnt_w(OUTPUT_DIM),
    parameter int PASS_W     = cnt_w(OUTPUT_DIM / TILE_OUT)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_we,
    input  logic [IDX_W-1:0]                    i_idx,
    input  logic [INPUT_DIM-1:0]                i_row,
    input  logic [PASS_W-1:0]                   i_pass,
    output logic [TILE_OUT-1:0][INPUT_DIM-1:0]  o_rows
);

    logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0] r_bank;

    // Out-of-range indices complete the handshake upstream but never land here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= '0;
        end else if (i_we && (int'(i_idx) < OUTPUT_DIM)) begin
            r_bank[i_idx] <= i_row;
        end
    end

    always_comb begin
        o_rows = '0;
        for (int t = 0; t < TILE_OUT; t++) begin
            o_rows[t] = r_bank[IDX_W'(int'(i_pass) * TILE_OUT + t)];
        end
    end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Latches an input vector and steps an external binary-weight tile over all output rows.
module bnn_layer_sequencer
    import bnn_ctrl_pkg::*;
#(
    parameter int INPUT_DIM  = INPUT_DIM_D,
    parameter int OUTPUT_DIM = OUTPUT_DIM_D,
    parameter int BIT_CNT    = BIT_CNT_D,
    parameter int TILE_OUT   = TILE_OUT_D,
    parameter int DP_LAT     = DP_LAT_D
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wt_valid,
    output logic                                 wt_ready,
    input  logic [$clog2(OUTPUT_DIM)-1:0]        wt_row_idx,
    input  logic [INPUT_DIM-1:0]                 wt_row,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [INPUT_DIM-1:0][BIT_CNT-1:0]    in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]   out_data,
    output logic [INPUT_DIM-1:0][BIT_CNT-1:0]    dp_value_in,
    output logic [TILE_OUT-1:0][INPUT_DIM-1:0]   dp_weight,
    input  logic [TILE_OUT-1:0][BIT_CNT-1:0]     dp_value_out,
    output logic                                 busy
);

    localparam int L_NPASS = OUTPUT_DIM / TILE_OUT;
    localparam int IDX_W   = cnt_w(OUTPUT_DIM);
    localparam int PASS_W  = cnt_w(L_NPASS);
    localparam int CNT_W   = cnt_w(DP_LAT);

    state_e                             r_state, w_next;
    logic [PASS_W-1:0]                  r_pass;
    logic [CNT_W-1:0]                   r_cnt;
    logic [INPUT_DIM-1:0][BIT_CNT-1:0]  r_x;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] r_out;
    logic                               r_out_valid;
    logic                               w_idle, w_capture, w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_idle    = 1'b0;
        w_capture = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle = 1'b1;
                if (in_valid) w_next = SETTLE;
            end
            SETTLE: begin
                if (r_cnt == CNT_W'(DP_LAT - 1)) begin
                    w_capture = 1'b1;
                    if (r_pass == PASS_W'(L_NPASS - 1)) begin
                        w_last = 1'b1;
                        w_next = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass      <= '0;
            r_cnt       <= '0;
            r_x         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x    <= in_data;
                        r_pass <= '0;
                        r_cnt  <= '0;
                    end
                end
                SETTLE: begin
                    if (w_capture) begin
                        for (int t = 0; t < TILE_OUT; t++) begin
                            r_out[IDX_W'(int'(r_pass) * TILE_OUT + t)] <= dp_value_out[t];
                        end
                        if (w_last) begin
                            r_out_valid <= 1'b1;
                        end else begin
                            r_pass <= r_pass + 1'b1;
                            r_cnt  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_pass      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Weight writes only in IDLE, so a same-cycle vector accept computes with the new row.
    bnn_weight_bank #(
        .INPUT_DIM (INPUT_DIM),
        .OUTPUT_DIM(OUTPUT_DIM),
        .TILE_OUT  (TILE_OUT),
        .IDX_W     (IDX_W),
        .PASS_W    (PASS_W)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (wt_valid & w_idle),
        .i_idx (IDX_W'(wt_row_idx)),
        .i_row (wt_row),
        .i_pass(r_pass),
        .o_rows(dp_weight)
    );

    assign wt_ready    = w_idle;
    assign in_ready    = w_idle;
    assign busy        = ~w_idle;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out;
    assign dp_value_in = r_x;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench for bnn_layer_sequencer with a combinational signed-sum tile model.
module tb_bnn_layer_sequencer;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  wt_valid;
    logic                  wt_ready;
    logic [2:0]            wt_row_idx;
    logic [3:0]            wt_row;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][7:0]       in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0][7:0]       out_data;
    logic [3:0][7:0]       dp_value_in;
    logic [1:0][3:0]       dp_weight;
    logic [1:0][7:0]       dp_value_out;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] X1234 = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] X9    = {8'd9, 8'd9, 8'd9, 8'd9};

    always #5 clk = ~clk;

    bnn_layer_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wt_valid    (wt_valid),
        .wt_ready    (wt_ready),
        .wt_row_idx  (wt_row_idx),
        .wt_row      (wt_row),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .dp_value_in (dp_value_in),
        .dp_weight   (dp_weight),
        .dp_value_out(dp_value_out),
        .busy        (busy)
    );

    // Tile model: out[k] = sum_j (w[k][j] ? +x[j] : -x[j]) mod 256.
    always_comb begin
        dp_value_out = '0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (dp_weight[k][j]) dp_value_out[k] = dp_value_out[k] + dp_value_in[j];
                else                 dp_value_out[k] = dp_value_out[k] - dp_value_in[j];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic [2:0] idx, input logic [3:0] row);
        wt_valid   = 1'b1;
        wt_row_idx = idx;
        wt_row     = row;
        tick();
        wt_valid   = 1'b0;
    endtask

    task automatic start(input logic [31:0] x);
        in_data  = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency and data, then completes the output handshake.
    task automatic finish_run(input string tag, input int exp_lat, input logic [63:0] exp);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; wt_valid = 1'b0; wt_row_idx = '0; wt_row = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_dp_weight", 64'(dp_weight), 64'd0);
        check("rst_dp_value_in", 64'(dp_value_in), 64'd0);
        check("rst_ready", 64'({in_ready, wt_ready}), 64'd3);
        #9 rst_n = 1'b1;
        tick();

        // 1: all rows 1111, x={1,2,3,4}
        for (int r = 0; r < 8; r++) write_row(3'(r), 4'b1111);
        start(X1234);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready", 64'({in_ready, wt_ready}), 64'd0);
        check("t1_dp_in", 64'(dp_value_in), 64'(X1234));
        finish_run("t1", 4, {8{8'h0A}});

        // 2: odd rows cleared
        for (int r = 1; r < 8; r += 2) write_row(3'(r), 4'b0000);
        start(X1234);
        finish_run("t2", 4, 64'hF60AF60AF60AF60A);

        // 3: stall in OUTPUT with in_valid held high
        start(X1234);
        for (int i = 0; i < 4; i++) tick();
        check("t3_vld", 64'(out_valid), 64'd1);
        in_data  = X9;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_vld", 64'(out_valid), 64'd1);
            check("t3_hold_data", out_data, 64'hF60AF60AF60AF60A);
            check("t3_in_ready", 64'(in_ready), 64'd0);
            check("t3_dp_in", 64'(dp_value_in), 64'(X1234));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_vld_drop", 64'(out_valid), 64'd0);
        check("t3_no_reaccept", 64'(busy), 64'd0);
        tick();
        check("t3_still_idle", 64'(busy), 64'd0);

        // 4: same-cycle row0 write and vector accept
        wt_valid = 1'b1; wt_row_idx = 3'd0; wt_row = 4'b0000;
        start(X1234);
        wt_valid = 1'b0;
        finish_run("t4", 4, 64'hF60AF60AF60AF6F6);

        // 5: weight write during SETTLE is refused
        start(X1234);
        wt_valid = 1'b1; wt_row_idx = 3'd1; wt_row = 4'b1111;
        check("t5_wt_ready", 64'(wt_ready), 64'd0);
        tick();
        wt_valid = 1'b0;
        finish_run("t5", 3, 64'hF60AF60AF60AF6F6);

        // 6: reset during pass 2 aborts and clears the bank
        start(X1234);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_vld", 64'(out_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_out_data", out_data, 64'd0);
        check("t6_dp_weight", 64'(dp_weight), 64'd0);
        #6 rst_n = 1'b1;
        tick();
        start(X1234);
        finish_run("t6", 4, {8{8'hF6}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
